countdown_timer: RTL and testbench



---
 rtl/countdown_timer.sv | 84 ++++++++
 tb/tb_countdown_timer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// Millisecond countdown timer. Loads a preset, decrements on each rising edge of the
// 1 kHz divider tick while running, and flags expiry when the count reaches zero.
module countdown_timer #(
  parameter int unsigned MAX_COUNT = 9999,
  localparam int unsigned W = $clog2(MAX_COUNT + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         tick_1khz,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         run,
  output logic [W-1:0] remaining_time,
  output logic         running,
  output logic         expired,
  output logic         expired_pulse
);

  typedef enum logic [1:0] {StIdle, StArmed, StRun, StExpired} state_e;

  state_e       state_q;
  logic         tick_q;
  logic         tick_rise;
  logic [W-1:0] load_clamped;

  assign tick_rise    = tick_1khz & ~tick_q;
  assign load_clamped = (load_value > W'(MAX_COUNT)) ? W'(MAX_COUNT) : load_value;

  // Outputs are registered alongside the state so they track state_q exactly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= StIdle;
      tick_q         <= 1'b0;
      remaining_time <= '0;
      running        <= 1'b0;
      expired        <= 1'b0;
      expired_pulse  <= 1'b0;
    end else begin
      tick_q        <= tick_1khz;
      expired_pulse <= 1'b0;
      if (load) begin
        remaining_time <= load_clamped;
        running        <= 1'b0;
        expired        <= 1'b0;
        state_q        <= (load_clamped != '0) ? StArmed : StIdle;
      end else begin
        unique case (state_q)
          StIdle: ;
          StArmed: begin
            if (run) begin
              state_q <= StRun;
              running <= 1'b1;
            end
          end
          StRun: begin
            // A pause coinciding with a tick edge wins; the tick is dropped.
            if (!run) begin
              state_q <= StArmed;
              running <= 1'b0;
            end else if (tick_rise) begin
              if (remaining_time > W'(1)) begin
                remaining_time <= remaining_time - W'(1);
              end else begin
                remaining_time <= '0;
                state_q        <= StExpired;
                running        <= 1'b0;
                expired        <= 1'b1;
                expired_pulse  <= 1'b1;
              end
            end
          end
          StExpired: ;
          default: begin
            state_q        <= StIdle;
            remaining_time <= '0;
            running        <= 1'b0;
            expired        <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboarded bench for countdown_timer: a per-cycle reference model pushes expected
// outputs, and a separate monitor pops and compares them after each clock edge.
module tb_countdown_timer;

  localparam int W   = 14;
  localparam int MAX = 9999;

  localparam int M_IDLE  = 0;
  localparam int M_ARMED = 1;
  localparam int M_RUN   = 2;
  localparam int M_EXP   = 3;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         tick_1khz = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_value = '0;
  logic         run = 1'b0;
  logic [W-1:0] remaining_time;
  logic         running;
  logic         expired;
  logic         expired_pulse;

  countdown_timer dut (
    .clk           (clk),
    .reset         (reset),
    .tick_1khz     (tick_1khz),
    .load          (load),
    .load_value    (load_value),
    .run           (run),
    .remaining_time(remaining_time),
    .running       (running),
    .expired       (expired),
    .expired_pulse (expired_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    int rem;
    bit run_o;
    bit exp_o;
    bit pulse;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   pulse_seen = 0;

  // Reference model state: remaining ms, mode, and last sampled tick level.
  int   m_rem = 0;
  int   m_mode = M_IDLE;
  bit   m_tick = 1'b0;
  bit   tk_lvl = 1'b0;

  task automatic cmp(input string name, input int act, input int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic step(input bit ld, input int lv, input bit rn, input bit tk);
    exp_t e;
    bit   rise;
    @(negedge clk);
    load       = ld;
    load_value = W'(lv);
    run        = rn;
    tick_1khz  = tk;
    rise   = tk && !m_tick;
    m_tick = tk;
    e.pulse = 1'b0;
    if (ld) begin
      m_rem  = (lv > MAX) ? MAX : lv;
      m_mode = (m_rem != 0) ? M_ARMED : M_IDLE;
    end else if (m_mode == M_ARMED && rn) begin
      m_mode = M_RUN;
    end else if (m_mode == M_RUN) begin
      if (!rn) m_mode = M_ARMED;
      else if (rise) begin
        m_rem = m_rem - 1;
        if (m_rem == 0) begin
          m_mode  = M_EXP;
          e.pulse = 1'b1;
        end
      end
    end
    e.rem   = m_rem;
    e.run_o = (m_mode == M_RUN);
    e.exp_o = (m_mode == M_EXP);
    sb.push_back(e);
  endtask

  // n tick periods of 2 cycles high, 2 cycles low.
  task automatic run_ticks(input bit rn, input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 0, rn, 1'b1);
      step(1'b0, 0, rn, 1'b1);
      step(1'b0, 0, rn, 1'b0);
      step(1'b0, 0, rn, 1'b0);
    end
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expired_pulse) pulse_seen++;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        cmp("sb_remaining", int'(remaining_time), e.rem);
        cmp("sb_running", int'(running), int'(e.run_o));
        cmp("sb_expired", int'(expired), int'(e.exp_o));
        cmp("sb_pulse", int'(expired_pulse), int'(e.pulse));
      end
    end
  end

  initial begin : driver
    int lv;
    #1;
    cmp("reset_remaining", int'(remaining_time), 0);
    cmp("reset_running", int'(running), 0);
    cmp("reset_expired", int'(expired), 0);
    cmp("reset_pulse", int'(expired_pulse), 0);
    @(negedge clk);
    reset = 1'b1;

    // Count 5 down to expiry
    pulse_seen = 0;
    step(1'b1, 5, 1'b1, 1'b0);
    run_ticks(1'b1, 6);
    after_edge();
    cmp("t1_remaining", int'(remaining_time), 0);
    cmp("t1_expired", int'(expired), 1);
    cmp("t1_running", int'(running), 0);
    cmp("t1_pulses", pulse_seen, 1);

    // Clamp and hold while paused
    step(1'b1, 12000, 1'b0, 1'b0);
    after_edge();
    cmp("t2_clamp", int'(remaining_time), 9999);
    cmp("t2_running", int'(running), 0);
    cmp("t2_expired", int'(expired), 0);
    run_ticks(1'b0, 3);
    after_edge();
    cmp("t2_hold", int'(remaining_time), 9999);

    // Pause and resume
    step(1'b1, 10, 1'b0, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0);
    run_ticks(1'b1, 3);
    after_edge();
    cmp("t3_after3", int'(remaining_time), 7);
    run_ticks(1'b0, 4);
    after_edge();
    cmp("t3_paused", int'(remaining_time), 7);
    step(1'b0, 0, 1'b1, 1'b1);
    after_edge();
    cmp("t3_resume_nodec", int'(remaining_time), 7);
    cmp("t3_resume_running", int'(running), 1);
    step(1'b0, 0, 1'b1, 1'b0);
    run_ticks(1'b1, 2);
    after_edge();
    cmp("t3_final", int'(remaining_time), 5);

    // Expire, then reload from EXPIRED
    pulse_seen = 0;
    run_ticks(1'b1, 6);
    step(1'b1, 3, 1'b1, 1'b0);
    after_edge();
    cmp("t4_exp_clear", int'(expired), 0);
    cmp("t4_reload", int'(remaining_time), 3);
    step(1'b0, 0, 1'b1, 1'b0);
    after_edge();
    cmp("t4_running", int'(running), 1);
    run_ticks(1'b1, 4);
    after_edge();
    cmp("t4_expired", int'(expired), 1);
    cmp("t4_pulses", pulse_seen, 2);

    // Load vs tick, pause vs tick
    step(1'b1, 4, 1'b1, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0);
    step(1'b1, 8, 1'b1, 1'b1);
    after_edge();
    cmp("t5_load_tick", int'(remaining_time), 8);
    step(1'b0, 0, 1'b1, 1'b1);
    step(1'b0, 0, 1'b1, 1'b0);
    step(1'b0, 0, 1'b0, 1'b1);
    after_edge();
    cmp("t5_pause_tick", int'(remaining_time), 8);
    cmp("t5_pause_running", int'(running), 0);
    step(1'b0, 0, 1'b0, 1'b0);

    // Asynchronous reset mid-count
    step(1'b1, 10, 1'b1, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0);
    run_ticks(1'b1, 4);
    after_edge();
    cmp("t6_pre_reset", int'(remaining_time), 6);
    @(negedge clk);
    #2;
    tick_1khz = 1'b0;
    reset = 1'b0;
    #1;
    cmp("t6_async_remaining", int'(remaining_time), 0);
    cmp("t6_async_running", int'(running), 0);
    cmp("t6_async_expired", int'(expired), 0);
    cmp("t6_async_pulse", int'(expired_pulse), 0);
    m_rem = 0;
    m_mode = M_IDLE;
    m_tick = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    step(1'b1, 0, 1'b0, 1'b0);
    after_edge();
    cmp("t6_load0_expired", int'(expired), 0);
    run_ticks(1'b1, 2);
    after_edge();
    cmp("t6_idle_remaining", int'(remaining_time), 0);
    cmp("t6_idle_running", int'(running), 0);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      bit ld;
      bit rn;
      if ($urandom_range(0, 2) == 0) tk_lvl = ~tk_lvl;
      ld = ($urandom_range(0, 39) == 0);
      case ($urandom_range(0, 3))
        0:       lv = 0;
        1:       lv = $urandom_range(1, 20);
        2:       lv = $urandom_range(10000, 16383);
        default: lv = $urandom_range(0, 16383);
      endcase
      rn = ($urandom_range(0, 9) != 0) ? run : ~run;
      step(ld, lv, rn, tk_lvl);
    end
    after_edge();
    cmp("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
